// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave in front of a DEPTH x DATA_BITS byte-writable SRAM array.
// Latency: write commits the cycle after both AW and W are held; read data 1 cycle after AR.
// Backpressure: one-deep AW/W holding registers stall while B is pending; AR stalls while R is pending.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_axi4lite_aw_*           write address (addr, prot ignored), valid/ready
//   s_axi4lite_w_*            write data and byte strobes, valid/ready
//   s_axi4lite_b_*            write response (OKAY / SLVERR), valid/ready
//   s_axi4lite_ar_*           read address (addr, prot ignored), valid/ready
//   s_axi4lite_r_*            read data and response, valid/ready
module axi4lite_sram_slave #(
   parameter int                   ADDR_BITS = 32,
   parameter int                   DATA_BITS = 64,
   parameter int                   DEPTH     = 256,
   parameter logic [ADDR_BITS-1:0] BASE      = 32'h8000_0000
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_axi4lite_aw_valid,
   output logic                     s_axi4lite_aw_ready,
   input  logic [ADDR_BITS-1:0]     s_axi4lite_aw_addr,
   input  logic [2:0]               s_axi4lite_aw_prot,
   input  logic                     s_axi4lite_w_valid,
   output logic                     s_axi4lite_w_ready,
   input  logic [DATA_BITS-1:0]     s_axi4lite_w_data,
   input  logic [DATA_BITS/8-1:0]   s_axi4lite_w_strb,
   output logic                     s_axi4lite_b_valid,
   input  logic                     s_axi4lite_b_ready,
   output logic [1:0]               s_axi4lite_b_resp,
   input  logic                     s_axi4lite_ar_valid,
   output logic                     s_axi4lite_ar_ready,
   input  logic [ADDR_BITS-1:0]     s_axi4lite_ar_addr,
   input  logic [2:0]               s_axi4lite_ar_prot,
   output logic                     s_axi4lite_r_valid,
   input  logic                     s_axi4lite_r_ready,
   output logic [DATA_BITS-1:0]     s_axi4lite_r_data,
   output logic [1:0]               s_axi4lite_r_resp
);

   localparam int STRB     = DATA_BITS / 8;
   localparam int IDX_BITS = $clog2(DEPTH);
   localparam int OFF_BITS = $clog2(STRB);
   // Window size in bytes, one bit wider than the address so it cannot wrap.
   localparam logic [ADDR_BITS:0] SPAN = (ADDR_BITS+1)'(DEPTH * STRB);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_BITS-1:0] mem [DEPTH];

   // Address decode: offset from BASE, hit only if at/above BASE and below BASE+SPAN.
   logic [ADDR_BITS-1:0] aw_off, ar_off;
   logic                 aw_hit, ar_hit;
   logic [IDX_BITS-1:0]  aw_idx, ar_idx;

   assign aw_off = s_axi4lite_aw_addr - BASE;
   assign ar_off = s_axi4lite_ar_addr - BASE;
   assign aw_hit = (s_axi4lite_aw_addr >= BASE) && ({1'b0, aw_off} < SPAN);
   assign ar_hit = (s_axi4lite_ar_addr >= BASE) && ({1'b0, ar_off} < SPAN);
   assign aw_idx = aw_off[OFF_BITS +: IDX_BITS];
   assign ar_idx = ar_off[OFF_BITS +: IDX_BITS];

   // Holding registers for the write address and write data channels.
   logic                 aw_full, w_full;
   logic                 aw_hit_q;
   logic [IDX_BITS-1:0]  aw_idx_q;
   logic [DATA_BITS-1:0] w_data_q;
   logic [STRB-1:0]      w_strb_q;
   logic                 wr_commit;

   assign s_axi4lite_aw_ready = !aw_full;
   assign s_axi4lite_w_ready  = !w_full;
   assign s_axi4lite_ar_ready = !s_axi4lite_r_valid;
   // A pending B response blocks the next commit, which in turn keeps AW/W stalled.
   assign wr_commit = aw_full && w_full && !s_axi4lite_b_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_full            <= 1'b0;
         w_full             <= 1'b0;
         aw_hit_q           <= 1'b0;
         aw_idx_q           <= '0;
         w_data_q           <= '0;
         w_strb_q           <= '0;
         s_axi4lite_b_valid <= 1'b0;
         s_axi4lite_b_resp  <= RESP_OKAY;
         s_axi4lite_r_valid <= 1'b0;
         s_axi4lite_r_data  <= '0;
         s_axi4lite_r_resp  <= RESP_OKAY;
      end else begin
         // AW capture and commit are mutually exclusive (capture needs !aw_full).
         if (s_axi4lite_aw_valid && !aw_full) begin
            aw_full  <= 1'b1;
            aw_hit_q <= aw_hit;
            aw_idx_q <= aw_idx;
         end
         if (s_axi4lite_w_valid && !w_full) begin
            w_full   <= 1'b1;
            w_data_q <= s_axi4lite_w_data;
            w_strb_q <= s_axi4lite_w_strb;
         end
         if (wr_commit) begin
            aw_full            <= 1'b0;
            w_full             <= 1'b0;
            s_axi4lite_b_valid <= 1'b1;
            s_axi4lite_b_resp  <= aw_hit_q ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi4lite_b_valid && s_axi4lite_b_ready) begin
            s_axi4lite_b_valid <= 1'b0;
         end

         // Read samples the array before any same-edge write lands (old data wins).
         if (s_axi4lite_ar_valid && !s_axi4lite_r_valid) begin
            s_axi4lite_r_valid <= 1'b1;
            s_axi4lite_r_data  <= ar_hit ? mem[ar_idx] : '0;
            s_axi4lite_r_resp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi4lite_r_valid && s_axi4lite_r_ready) begin
            s_axi4lite_r_valid <= 1'b0;
         end
      end
   end

   // Array has no reset; commit is impossible in reset since the holding flags are clear.
   always_ff @(posedge clk) begin
      if (wr_commit && aw_hit_q) begin
         for (int i = 0; i < STRB; i++) begin
            if (w_strb_q[i]) mem[aw_idx_q][i*8 +: 8] <= w_data_q[i*8 +: 8];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, s_axi4lite_aw_prot, s_axi4lite_ar_prot, aw_off, ar_off};

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
module tb_axi4lite_sram_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_valid, r_ready;
   logic [31:0] aw_addr, ar_addr;
   logic [2:0]  aw_prot, ar_prot;
   logic [63:0] w_data, r_data;
   logic [7:0]  w_strb;
   logic [1:0]  b_resp, r_resp;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
   } rexp_t;

   rexp_t       r_q[$];
   logic [1:0]  b_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   axi4lite_sram_slave dut (
      .clk(clk), .rstn(rstn),
      .s_axi4lite_aw_valid(aw_valid), .s_axi4lite_aw_ready(aw_ready),
      .s_axi4lite_aw_addr(aw_addr), .s_axi4lite_aw_prot(aw_prot),
      .s_axi4lite_w_valid(w_valid), .s_axi4lite_w_ready(w_ready),
      .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb),
      .s_axi4lite_b_valid(b_valid), .s_axi4lite_b_ready(b_ready),
      .s_axi4lite_b_resp(b_resp),
      .s_axi4lite_ar_valid(ar_valid), .s_axi4lite_ar_ready(ar_ready),
      .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
      .s_axi4lite_r_valid(r_valid), .s_axi4lite_r_ready(r_ready),
      .s_axi4lite_r_data(r_data), .s_axi4lite_r_resp(r_resp)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Stimulus drivers: called on a negedge, return on the negedge after the handshake edge.
   task automatic send_aw(input logic [31:0] a, output bit ok);
      ok = 0; aw_addr = a; aw_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (aw_ready) ok = 1;
         @(negedge clk);
      end
      aw_valid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s, output bit ok);
      ok = 0; w_data = d; w_strb = s; w_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (w_ready) ok = 1;
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output bit ok);
      ok = 0; ar_addr = a; ar_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (ar_ready) ok = 1;
         @(negedge clk);
      end
      ar_valid = 1'b0;
   endtask

   task automatic write_pair(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             output bit ok);
      bit ok1, ok2;
      fork
         send_aw(a, ok1);
         send_w(d, s, ok2);
      join
      ok = ok1 && ok2;
   endtask

   // Bounded waits: return at once if the response is already valid.
   task automatic wait_b(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (b_valid) ok = 1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_r(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (r_valid) ok = 1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (aw_ready !== 1'b1 || w_ready !== 1'b1 || ar_ready !== 1'b1 ||
          b_valid !== 1'b0 || r_valid !== 1'b0 || r_data !== 64'h0 ||
          b_resp !== 2'b00 || r_resp !== 2'b00) begin
         errors++;
         $display("FAIL reset_state got aw_rdy=%b w_rdy=%b ar_rdy=%b b_vld=%b r_vld=%b r_data=%h b_resp=%b r_resp=%b exp 1 1 1 0 0 0 00 00",
                  aw_ready, w_ready, ar_ready, b_valid, r_valid, r_data, b_resp, r_resp);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      bit ok, ok2; rexp_t re; logic [1:0] be;
      write_pair(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, ok);
      b_q.push_back(2'b00);
      wait_b(ok2); be = b_q.pop_front();
      checks++;
      if (!(ok && ok2) || b_resp !== be) begin
         errors++; $display("FAIL wr_full_b got resp=%b ok=%b exp resp=%b", b_resp, ok && ok2, be);
      end
      @(negedge clk);
      r_q.push_back({64'h1122_3344_5566_7788, 2'b00});
      send_ar(32'h8000_0008, ok);
      checks++;
      if (!ok || r_valid !== 1'b1) begin
         errors++; $display("FAIL rd_latency got r_valid=%b one cycle after AR exp 1", r_valid);
      end
      wait_r(ok2); re = r_q.pop_front();
      checks++;
      if (!ok2 || r_data !== re.data || r_resp !== re.resp) begin
         errors++; $display("FAIL rd_full got %h/%b exp %h/%b", r_data, r_resp, re.data, re.resp);
      end
      @(negedge clk);
   endtask

   task automatic test_w_before_aw();
      bit ok, ok2; rexp_t re; logic [1:0] be;
      send_w(64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, ok);
      b_q.push_back(2'b00);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || b_valid !== 1'b0 || w_ready !== 1'b0) begin
         errors++; $display("FAIL w_only_hold got b_valid=%b w_ready=%b exp 0 0", b_valid, w_ready);
      end
      send_aw(32'h8000_0008, ok);
      checks++;
      if (!ok || b_valid !== 1'b0) begin
         errors++; $display("FAIL w_first_b_early got b_valid=%b exp 0", b_valid);
      end
      wait_b(ok2); be = b_q.pop_front();
      checks++;
      if (!ok2 || b_resp !== be) begin
         errors++; $display("FAIL w_first_b got resp=%b exp %b", b_resp, be);
      end
      @(negedge clk);
      r_q.push_back({64'h1122_3344_BBBB_BBBB, 2'b00});
      send_ar(32'h8000_0008, ok); wait_r(ok2); re = r_q.pop_front();
      checks++;
      if (!(ok && ok2) || r_data !== re.data || r_resp !== re.resp) begin
         errors++; $display("FAIL rd_strb got %h/%b exp %h/%b", r_data, r_resp, re.data, re.resp);
      end
      @(negedge clk);
   endtask

   task automatic test_out_of_range();
      bit ok, ok2; rexp_t re; logic [1:0] be;
      logic [31:0] wa [3] = '{32'h8000_0000, 32'h8000_0800, 32'h8000_07FF};
      logic [63:0] wd [3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_1234_5678};
      logic [1:0]  wr [3] = '{2'b00, 2'b10, 2'b00};
      logic [31:0] ra [4] = '{32'h8000_0800, 32'h8000_0000, 32'h7FFF_FFF8, 32'h8000_07F8};
      rexp_t       rx [4] = '{{64'h0, 2'b10}, {64'h0, 2'b00}, {64'h0, 2'b10},
                              {64'hCAFE_F00D_1234_5678, 2'b00}};
      for (int i = 0; i < 3; i++) begin
         write_pair(wa[i], wd[i], 8'hFF, ok);
         b_q.push_back(wr[i]);
         wait_b(ok2); be = b_q.pop_front();
         checks++;
         if (!(ok && ok2) || b_resp !== be) begin
            errors++; $display("FAIL range_b[%0d] addr %h got resp=%b exp %b", i, wa[i], b_resp, be);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         r_q.push_back(rx[i]);
         send_ar(ra[i], ok); wait_r(ok2); re = r_q.pop_front();
         checks++;
         if (!(ok && ok2) || r_data !== re.data || r_resp !== re.resp) begin
            errors++; $display("FAIL range_rd[%0d] addr %h got %h/%b exp %h/%b",
                               i, ra[i], r_data, r_resp, re.data, re.resp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_b_backpressure();
      bit ok, ok2; rexp_t re; logic [1:0] be;
      b_ready = 1'b0;
      write_pair(32'h8000_0010, 64'h0101_0202_0303_0404, 8'hFF, ok);
      b_q.push_back(2'b00);
      wait_b(ok2);
      write_pair(32'h8000_0018, 64'h0505_0606_0707_0808, 8'hFF, ok);
      b_q.push_back(2'b00);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (!(ok && ok2) || b_valid !== 1'b1 || b_resp !== b_q[0] || aw_ready !== 1'b0 || w_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got b_vld=%b resp=%b aw_rdy=%b w_rdy=%b exp 1 %b 0 0",
                               i, b_valid, b_resp, aw_ready, w_ready, b_q[0]);
         end
         @(negedge clk);
      end
      b_ready = 1'b1;
      be = b_q.pop_front();
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b0 || aw_ready !== 1'b0) begin
         errors++; $display("FAIL bp_gap got b_vld=%b aw_rdy=%b exp 0 0", b_valid, aw_ready);
      end
      @(negedge clk);
      be = b_q.pop_front();
      checks++;
      if (b_valid !== 1'b1 || b_resp !== be || aw_ready !== 1'b1 || w_ready !== 1'b1) begin
         errors++; $display("FAIL bp_second got b_vld=%b resp=%b aw_rdy=%b w_rdy=%b exp 1 %b 1 1",
                            b_valid, b_resp, aw_ready, w_ready, be);
      end
      @(negedge clk);
      r_q.push_back({64'h0101_0202_0303_0404, 2'b00});
      r_q.push_back({64'h0505_0606_0707_0808, 2'b00});
      for (int i = 0; i < 2; i++) begin
         send_ar(32'h8000_0010 + 32'(i * 8), ok); wait_r(ok2); re = r_q.pop_front();
         checks++;
         if (!(ok && ok2) || r_data !== re.data || r_resp !== re.resp) begin
            errors++; $display("FAIL bp_rd[%0d] got %h/%b exp %h/%b", i, r_data, r_resp, re.data, re.resp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rw_collision();
      bit ok, ok2, ok3; rexp_t re; logic [1:0] be;
      // AW/W captured on edge P; the AR below handshakes on P+1, the commit edge.
      write_pair(32'h8000_0000, 64'h5, 8'hFF, ok);
      b_q.push_back(2'b00);
      r_q.push_back({64'h0, 2'b00});
      send_ar(32'h8000_0000, ok2); wait_r(ok3); re = r_q.pop_front();
      checks++;
      if (!(ok && ok2 && ok3) || r_data !== re.data || r_resp !== re.resp) begin
         errors++; $display("FAIL collide_old got %h/%b exp %h/%b", r_data, r_resp, re.data, re.resp);
      end
      wait_b(ok); be = b_q.pop_front();
      checks++;
      if (!ok || b_resp !== be) begin
         errors++; $display("FAIL collide_b got resp=%b exp %b", b_resp, be);
      end
      @(negedge clk);
      r_q.push_back({64'h5, 2'b00});
      send_ar(32'h8000_0000, ok); wait_r(ok2); re = r_q.pop_front();
      checks++;
      if (!(ok && ok2) || r_data !== re.data || r_resp !== re.resp) begin
         errors++; $display("FAIL collide_new got %h/%b exp %h/%b", r_data, r_resp, re.data, re.resp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok, ok2; rexp_t re;
      r_ready = 1'b0; b_ready = 1'b0;
      send_ar(32'h8000_0000, ok);
      write_pair(32'h8000_0020, 64'h77, 8'hFF, ok);
      wait_b(ok2);
      // Second write is held in AW/W because B is still pending.
      write_pair(32'h8000_0008, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, ok);
      checks++;
      if (!(ok && ok2) || r_valid !== 1'b1 || aw_ready !== 1'b0 || b_valid !== 1'b1) begin
         errors++; $display("FAIL mid_setup got r_vld=%b aw_rdy=%b b_vld=%b exp 1 0 1", r_valid, aw_ready, b_valid);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (r_valid !== 1'b0 || aw_ready !== 1'b1 || w_ready !== 1'b1 || b_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset got r_vld=%b aw_rdy=%b w_rdy=%b b_vld=%b exp 0 1 1 0",
                            r_valid, aw_ready, w_ready, b_valid);
      end
      @(negedge clk);
      rstn = 1'b1; r_ready = 1'b1; b_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (b_valid !== 1'b0 || r_valid !== 1'b0) begin
         errors++; $display("FAIL mid_after got b_vld=%b r_vld=%b exp 0 0", b_valid, r_valid);
      end
      r_q.push_back({64'h1122_3344_BBBB_BBBB, 2'b00});
      send_ar(32'h8000_0008, ok); wait_r(ok2); re = r_q.pop_front();
      checks++;
      if (!(ok && ok2) || r_data !== re.data || r_resp !== re.resp) begin
         errors++; $display("FAIL mid_nowrite got %h/%b exp %h/%b", r_data, r_resp, re.data, re.resp);
      end
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      aw_valid = 1'b0; aw_addr = '0; aw_prot = '0;
      w_valid = 1'b0;  w_data = '0;  w_strb = '0;
      ar_valid = 1'b0; ar_addr = '0; ar_prot = '0;
      b_ready = 1'b1;  r_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_w_before_aw();
      test_out_of_range();
      test_b_backpressure();
      test_rw_collision();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
